// File: rtl/video_pkg.sv
// Shared video timing constants (640x480@60 defaults) and small decode helpers
// reused by the video blocks.
package video_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // True when lo <= v < hi.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running pixel/line counters gated by pix_ce, with
// registered sync/enable decode and line/frame start pulses aligned to draw_x/draw_y.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic             Clk,
  input  logic             reset_rtl_0,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             vde,
  output logic [CNT_W-1:0] draw_x,
  output logic [CNT_W-1:0] draw_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_count
);

  localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [CNT_W-1:0] hc;
  logic [CNT_W-1:0] vc;

  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      hc          <= '0;
      vc          <= '0;
      frame_count <= '0;
    end else if (pix_ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        if (vc == V_LAST) begin
          vc          <= '0;
          frame_count <= frame_count + 16'd1;
        end else begin
          vc <= vc + 1'b1;
        end
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Outputs show the counter pair from the previous pix_ce cycle, so every
  // decoded signal and both pulses share one fixed latency.
  always_ff @(posedge Clk) begin
    if (!reset_rtl_0) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vde         <= 1'b0;
      draw_x      <= '0;
      draw_y      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        hsync       <= !in_window(hc, HS_START, HS_END);
        vsync       <= !in_window(vc, VS_START, VS_END);
        vde         <= (hc < H_VIS) && (vc < V_VIS);
        draw_x      <= hc;
        draw_y      <= vc;
        line_start  <= (hc == '0);
        frame_start <= (hc == '0) && (vc == '0);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a shrunken raster so whole frames
// fit in a short run; expected outputs come from pixel-count arithmetic.
module tb_video_timing_gen;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        ls;
    logic        fs;
    logic [15:0] fc;
  } vec_t;

  localparam vec_t RST_VEC = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: '0, y: '0,
                               ls: 1'b0, fs: 1'b0, fc: '0};

  logic        Clk = 1'b0;
  logic        reset_rtl_0 = 1'b0;
  logic        pix_ce = 1'b0;
  logic        hsync, vsync, vde, line_start, frame_start;
  logic [9:0]  draw_x, draw_y;
  logic [15:0] frame_count;

  int   vectors = 0;
  int   miscompares = 0;
  int   n = 0;
  vec_t prev_exp = RST_VEC;
  vec_t exp_q[$];

  always #5 Clk = ~Clk;

  video_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .Clk(Clk), .reset_rtl_0(reset_rtl_0), .pix_ce(pix_ce),
    .hsync(hsync), .vsync(vsync), .vde(vde),
    .draw_x(draw_x), .draw_y(draw_y),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  // After the k-th pix_ce since reset the outputs show raster position k-1,
  // and k/FT frames have been completed.
  function automatic vec_t model(input int k);
    vec_t v;
    int p, x, y;
    p = (k - 1) % FT;
    x = p % HT;
    y = p / HT;
    v.hs = !((x >= HV + HF) && (x < HV + HF + HS));
    v.vs = !((y >= VV + VF) && (y < VV + VF + VS));
    v.de = (x < HV) && (y < VV);
    v.x  = 10'(x);
    v.y  = 10'(y);
    v.ls = (x == 0);
    v.fs = (p == 0);
    v.fc = 16'(k / FT);
    return v;
  endfunction

  task automatic step(input bit rst, input bit ce);
    vec_t e;
    @(negedge Clk);
    reset_rtl_0 = !rst;
    pix_ce      = ce;
    if (rst) begin
      n = 0;
      e = RST_VEC;
      prev_exp = e;
    end else if (ce) begin
      n++;
      e = model(n);
      prev_exp = e;
    end else begin
      e = prev_exp;
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    vec_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        check("hsync", 16'(hsync), 16'(e.hs));
        check("vsync", 16'(vsync), 16'(e.vs));
        check("vde", 16'(vde), 16'(e.de));
        check("draw_x", 16'(draw_x), 16'(e.x));
        check("draw_y", 16'(draw_y), 16'(e.y));
        check("line_start", 16'(line_start), 16'(e.ls));
        check("frame_start", 16'(frame_start), 16'(e.fs));
        check("frame_count", frame_count, e.fc);
      end
    end
  end

  initial begin : stimulus
    bit hit;
    // Reset, with pix_ce high to show reset wins.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    // Continuous pixel clock enable across two frame boundaries.
    for (int i = 0; i < 2 * FT + 50; i++) step(1'b0, 1'b1);
    // One enable in four.
    for (int i = 0; i < 4 * FT; i++) step(1'b0, $urandom_range(0, 3) == 0);
    // Random enable density, then reset mid-frame at raster (20, 8).
    hit = 1'b0;
    for (int i = 0; i < 4 * FT && !hit; i++) begin
      if (n > 0 && ((n - 1) % FT) == 8 * HT + 20) begin
        hit = 1'b1;
        step(1'b1, 1'b1);
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)));
      end
    end
    if (!hit) begin
      miscompares++;
      $display("FAIL mid_frame_reset: got no hit want position (20,8) reached");
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < FT + 40; i++) step(1'b0, 1'b1);
    // Random reset pulses mixed with random enables.
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
